// File: rtl/seq_penc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// Optional macro SEQ_PENC_MSB_FIRST_EN reverses the scan order.
package seq_penc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Index width that never collapses to zero, even for tiny N.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_priority_encoder_penc_core.sv
// Combinational priority core: index of the first set bit plus population flags.
// SEQ_PENC_MSB_FIRST_EN selects highest-bit-first; default is lowest-bit-first.
module penc_core
    import seq_penc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Later loop iterations override earlier ones, so the winning bit is the
    // last one visited; an all-zero vector leaves idx at 0.
    always_comb begin
        idx = '0;
`ifdef SEQ_PENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++)
            if (vec[i]) idx = IDX_W'(i);
`else
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
`endif
    end

    assign any   = |vec;
    assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/seq_priority_encoder.sv
// Serialises a latched multi-hot vector into one index per output handshake.
// Build option: define SEQ_PENC_MSB_FIRST_EN for highest-index-first order.
module seq_priority_encoder
    import seq_penc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
);

    state_t           state;
    logic [N-1:0]     pend;
    logic             none_q;
    logic [IDX_W-1:0] core_idx;
    logic             core_any;
    logic             core_multi;
    logic [N-1:0]     clr_mask;
    logic             in_fire;
    logic             out_fire;

    penc_core #(.N(N)) u_core (
        .vec   (pend),
        .idx   (core_idx),
        .any   (core_any),
        .multi (core_multi)
    );

    // in_ready is forced low while reset is held, and rises with release.
    assign in_ready  = (state == ST_IDLE) && rst_n;
    assign out_valid = (state == ST_SCAN);
    assign out_idx   = out_valid ? core_idx : '0;
    assign out_last  = out_valid && !core_multi;
    assign out_none  = out_valid && none_q;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    // The dummy beat of an all-zero vector has no bit to clear.
    assign clr_mask  = core_any ? (N'(1) << core_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pend   <= '0;
            none_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        pend   <= in_vec;
                        none_q <= ~|in_vec;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (out_fire) begin
                        pend <= pend & ~clr_mask;
                        if (out_last) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
- Parametrised, sequential successor to the team's fixed 8:3 combinational encoder.
- Accepts an N-bit request vector through a valid/ready handshake and latches it.
- Emits the binary index of every set bit, one per output handshake, lowest index first by default, marking the final index.
- Used wherever a multi-hot status or interrupt vector must be serialised into indices for a downstream single-index consumer.

Parameters:
- N, 8, input vector width; legal range 2..256.
- IDX_W, $clog2(N) (localparam, not overridable), output index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; one clock; asserts asynchronously.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  multi-hot request vector.
- out_valid  output  1  out_idx/out_last/out_none are valid.
- out_ready  input  1  consumer accepts current beat.
- out_idx  output  IDX_W  index of the current set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_none  output  1  latched vector was all-zero (single dummy beat).

Behaviour:
- State machine with two states, IDLE and SCAN. Internal register pend[N-1:0] holds the bits not yet emitted.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pend=0.
  - in_ready=1 is the first value after reset release; held 0 during reset.
  - out_valid=0, out_idx=0, out_last=0, out_none=0.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid&in_ready on an edge: pend<=in_vec, none_q<=(in_vec==0), go to SCAN.
- SCAN:
  - in_ready=0, out_valid=1.
  - out_idx = position of the lowest set bit of pend; all outputs are combinational from registers.
  - out_last=1 when pend has at most one bit set.
  - out_none=none_q. An all-zero vector gives exactly one beat: out_idx=0, out_none=1, out_last=1.
  - out_valid&out_ready: clear the emitted bit in pend; if out_last, go to IDLE.
  - out_ready=0: hold all outputs stable; out_valid is never dropped without a handshake.
- Latency and throughput:
  - First out_valid appears 1 cycle after the input handshake.
  - One index per cycle while out_ready=1.
  - An input handshake for a vector with k set bits occupies max(k,1) output beats plus 1 idle cycle before the next accept. No overlap between vectors.
- in_vec changes while in SCAN are ignored; only the latched copy is used.
- in_valid while in_ready=0 is not accepted. The source must hold it, per standard valid/ready rules.
- Reset mid-SCAN discards pend immediately; no partial beat is emitted after release.
- N not a power of two: out_idx never exceeds N-1.

Optional Feature:
- Macro: SEQ_PENC_MSB_FIRST_EN.
- Defined: scan order reverses. out_idx is the highest set bit of pend, and out_last is unchanged in meaning. An all-zero vector still yields out_idx=0.
- Undefined: lowest-index-first order as above.

Decomposition:
- Package seq_penc_pkg:
  - State enum (ST_IDLE, ST_SCAN).
  - Helper constant function clog2_min1, returning at least 1 for IDX_W.
- Sub-module penc_core (combinational, parametrised N):
  - in: vec[N-1:0]; out: idx[IDX_W-1:0], any, multi (more than one bit set).
  - Direction is selected by the same macro.
- The top level contains the FSM, pend register and handshake logic.

Test Plan:
- Reset then N=8, in_vec=8'b1010_0110, out_ready=1 -> out_idx sequence 1,2,5,7 on consecutive cycles; out_last only on 7; in_ready=1 the cycle after.
- in_vec=8'h00 -> single beat: out_idx=0, out_none=1, out_last=1; back to IDLE.
- in_vec=8'h81, out_ready toggling 0,0,1,0,1 -> out_idx holds 0 through stalls, then 7 with out_last; no beat is lost or duplicated.
- in_vec=8'hFF, rst_n pulsed low after 3 beats (indices 0,1,2) -> outputs drop asynchronously to reset values; after release in_ready=1 and no further beats.
- N=5, in_vec=5'b10001 with SEQ_PENC_MSB_FIRST_EN defined -> out_idx 4 then 0 (last). Undefined -> 0 then 4 (last).
- Random vectors, 1000 iterations, random out_ready -> the multiset of emitted indices equals the set bits; scoreboard checks order and out_last.
